// File: rtl/id_decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_decode_stage_pkg
// Shared definitions for the ID stage: opcode constants, EXE command and
// branch-type encodings, the swap-sequencer state type, the control word
// produced by opcode decode, and the decode function itself.
// ---------------------------------------------------------------------------
package id_decode_stage_pkg;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;
  localparam logic [5:0] OP_SWP  = 6'd48;

  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_ADD = 4'd1,
    EXE_SUB = 4'd2,
    EXE_AND = 4'd3,
    EXE_OR  = 4'd4,
    EXE_XOR = 4'd5,
    EXE_SLL = 4'd6,
    EXE_SRL = 4'd7
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SWP1 = 2'd1,
    ST_SWP2 = 2'd2
  } swp_state_e;

  typedef struct packed {
    exe_cmd_e exe_cmd;
    br_type_e br_type;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     wb_en;
    logic     is_imm;
    logic     single_src;  // reads src1 only (or nothing)
    logic     is_swp;
  } ctrl_t;

  // Also the bubble control word: nothing enabled, EXE does nothing.
  localparam ctrl_t CTRL_NOP = '{exe_cmd: EXE_NOP, br_type: BR_NONE, mem_r_en: 1'b0,
                                 mem_w_en: 1'b0, wb_en: 1'b0, is_imm: 1'b0,
                                 single_src: 1'b1, is_swp: 1'b0};

  // Every swap micro-op is an XOR of the two swap registers written back.
  localparam ctrl_t CTRL_SWP = '{exe_cmd: EXE_XOR, br_type: BR_NONE, mem_r_en: 1'b0,
                                 mem_w_en: 1'b0, wb_en: 1'b1, is_imm: 1'b0,
                                 single_src: 1'b0, is_swp: 1'b1};

  function automatic ctrl_t mk_ctrl(input exe_cmd_e cmd, input br_type_e br,
                                    input logic rd, input logic wr, input logic wb,
                                    input logic imm, input logic single);
    ctrl_t c;
    c = '{exe_cmd: cmd, br_type: br, mem_r_en: rd, mem_w_en: wr, wb_en: wb,
          is_imm: imm, single_src: single, is_swp: 1'b0};
    return c;
  endfunction

  // Unknown opcodes decode as NOP; SWP decodes as NOP when the sequencer is off.
  function automatic ctrl_t decode_op(input logic [5:0] op, input logic swp_en);
    ctrl_t c;
    case (op)
      OP_ADD:  c = mk_ctrl(EXE_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_SUB:  c = mk_ctrl(EXE_SUB, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_AND:  c = mk_ctrl(EXE_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_OR:   c = mk_ctrl(EXE_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_XOR:  c = mk_ctrl(EXE_XOR, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_SLL:  c = mk_ctrl(EXE_SLL, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_SRL:  c = mk_ctrl(EXE_SRL, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_ADDI: c = mk_ctrl(EXE_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      OP_SUBI: c = mk_ctrl(EXE_SUB, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      OP_LD:   c = mk_ctrl(EXE_ADD, BR_NONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      // Store: address = src1 + imm, store data travels on reg2.
      OP_ST:   c = mk_ctrl(EXE_ADD, BR_NONE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      OP_BEZ:  c = mk_ctrl(EXE_NOP, BR_BEZ,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_BNE:  c = mk_ctrl(EXE_NOP, BR_BNE,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_JMP:  c = mk_ctrl(EXE_NOP, BR_JMP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_SWP:  c = swp_en ? CTRL_SWP : CTRL_NOP;
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// ---------------------------------------------------------------------------
// id_regfile
// Register file with two combinational read ports, one write port and
// write-through bypass. Register 0 always reads 0 and ignores writes.
// Ports: clk, rst (sync, active-high, clears all entries),
//        raddr1/rdata1, raddr2/rdata2 read ports, we/waddr/wdata write port.
// ---------------------------------------------------------------------------
module id_regfile #(
  parameter  int DATA_W    = 32,
  parameter  int REG_COUNT = 32,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [REG_COUNT];

  // NOTE: this array is deliberately reset (architectural state must read 0
  // after reset); that forces flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // Bypass lets ID see a value being written back in the same cycle.
  assign rdata1 = (raddr1 == '0)              ? '0    :
                  (we && waddr == raddr1)     ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == '0)              ? '0    :
                  (we && waddr == raddr2)     ? wdata : mem[raddr2];

endmodule

// File: rtl/id_decode_stage.sv
// ---------------------------------------------------------------------------
// id_decode_stage
// Instruction-decode pipeline stage: decodes instr, reads the register file,
// and registers the ID/EXE bundle. A three-step XOR sequencer expands SWP
// into micro-ops, freezing IF while it runs.
// Ports: clk, rst (sync, active-high)
//   IF:     instr, instr_valid; freeze (hold PC/instr this cycle)
//   WB:     wb_we, wb_dest, wb_data
//   Hazard: hazard (stall), flush (kill); src1, src2, single_src (to hazard unit)
//   ID/EXE: ex_valid, dest, val1, val2, reg2, exe_cmd, br_type,
//           mem_r_en, mem_w_en, wb_en (all registered)
// ---------------------------------------------------------------------------
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int REG_COUNT = 32,
  parameter  int IMM_W     = 16,
  parameter  int SWP_EN    = 1,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hazard,
  input  logic              flush,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic              single_src,
  output logic              freeze,
  output logic              ex_valid,
  output logic [REG_AW-1:0] dest,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] reg2,
  output logic [3:0]        exe_cmd,
  output logic [1:0]        br_type,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en
);

  swp_state_e        state_q;
  logic [REG_AW-1:0] swp_a_q, swp_b_q;  // swap operands captured at SWP entry

  ctrl_t             dec_ctrl, uop_ctrl, nx_ctrl;
  logic [REG_AW-1:0] f_src1, f_src2, f_rd, nx_dest;
  logic [DATA_W-1:0] rd1, rd2, imm_ext, nx_val1, nx_val2, nx_reg2;
  logic              in_swp, swp_start, bubble;

  assign f_src1   = REG_AW'(instr[25:21]);
  assign f_src2   = REG_AW'(instr[20:16]);
  assign f_rd     = REG_AW'(instr[15:11]);
  assign imm_ext  = DATA_W'($signed(instr[IMM_W-1:0]));
  assign dec_ctrl = decode_op(instr[31:26], SWP_EN != 0);

  // While sequencing, the held instr is ignored: operands come from the
  // captured swap registers and instr_valid no longer gates issue.
  assign in_swp     = (state_q != ST_IDLE);
  assign swp_start  = !in_swp && instr_valid && dec_ctrl.is_swp;
  assign uop_ctrl   = in_swp ? CTRL_SWP : dec_ctrl;
  assign src1       = in_swp ? swp_a_q : f_src1;
  assign src2       = in_swp ? swp_b_q : f_src2;
  assign single_src = uop_ctrl.single_src;
  assign bubble     = flush || hazard || !(in_swp || instr_valid);
  assign freeze     = !flush && (hazard || swp_start || state_q == ST_SWP1);

  id_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .we     (wb_we),
    .waddr  (wb_dest),
    .wdata  (wb_data)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nx_ctrl = CTRL_NOP;
    nx_dest = '0;
    nx_val1 = '0;
    nx_val2 = '0;
    nx_reg2 = '0;
    if (!bubble) begin
      nx_ctrl = uop_ctrl;
      nx_val1 = rd1;
      nx_reg2 = rd2;
      nx_val2 = uop_ctrl.is_imm ? imm_ext : rd2;
      if (uop_ctrl.is_swp) begin
        // XOR swap: a^=b, b^=a, a^=b
        nx_dest = (state_q == ST_SWP1) ? src2 : src1;
      end else begin
        nx_dest = uop_ctrl.is_imm ? f_src2 : f_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      swp_a_q  <= '0;
      swp_b_q  <= '0;
      ex_valid <= 1'b0;
      dest     <= '0;
      val1     <= '0;
      val2     <= '0;
      reg2     <= '0;
      exe_cmd  <= EXE_NOP;
      br_type  <= BR_NONE;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      wb_en    <= 1'b0;
    end else begin
      ex_valid <= !bubble;
      dest     <= nx_dest;
      val1     <= nx_val1;
      val2     <= nx_val2;
      reg2     <= nx_reg2;
      exe_cmd  <= nx_ctrl.exe_cmd;
      br_type  <= nx_ctrl.br_type;
      mem_r_en <= nx_ctrl.mem_r_en;
      mem_w_en <= nx_ctrl.mem_w_en;
      wb_en    <= nx_ctrl.wb_en;

      if (flush) begin
        state_q <= ST_IDLE;
      end else if (!hazard) begin
        case (state_q)
          ST_IDLE: if (swp_start) begin
            state_q <= ST_SWP1;
            swp_a_q <= f_src1;
            swp_b_q <= f_src2;
          end
          ST_SWP1: state_q <= ST_SWP2;
          ST_SWP2: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_id_decode_stage
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model: an architectural register array, an opcode table, and a
// queue of the destinations still owed by an in-progress swap.
// ---------------------------------------------------------------------------
module tb_id_decode_stage;
  import id_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        hazard, flush;
  logic [4:0]  src1, src2, dest;
  logic        single_src, freeze, ex_valid;
  logic [31:0] val1, val2, reg2;
  logic [3:0]  exe_cmd;
  logic [1:0]  br_type;
  logic        mem_r_en, mem_w_en, wb_en;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .hazard(hazard), .flush(flush),
    .src1(src1), .src2(src2), .single_src(single_src), .freeze(freeze),
    .ex_valid(ex_valid), .dest(dest), .val1(val1), .val2(val2), .reg2(reg2),
    .exe_cmd(exe_cmd), .br_type(br_type),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] cmd; logic [1:0] br; logic r, w, wb, imm, single;
  } ref_t;

  typedef struct packed {
    logic valid; logic [4:0] dest; logic [31:0] v1, v2, r2;
    logic [3:0] cmd; logic [1:0] br; logic r, w, wb;
  } ex_t;

  logic [31:0] m_regs [32];
  logic [4:0]  pend [$];      // destinations of swap micro-ops still to come
  logic [4:0]  m_a, m_b;
  ex_t         e = '0;        // expected ID/EXE bundle after the last edge
  logic        obs_freeze;

  function automatic ref_t mk(input logic [3:0] c, input logic [1:0] b, input logic r,
                              input logic w, input logic wb, input logic imm, input logic s);
    ref_t t;
    t.cmd = c; t.br = b; t.r = r; t.w = w; t.wb = wb; t.imm = imm; t.single = s;
    return t;
  endfunction

  function automatic ref_t ref_ctrl(input logic [5:0] op);
    case (op)
      OP_ADD:  return mk(EXE_ADD, BR_NONE, 0, 0, 1, 0, 0);
      OP_SUB:  return mk(EXE_SUB, BR_NONE, 0, 0, 1, 0, 0);
      OP_AND:  return mk(EXE_AND, BR_NONE, 0, 0, 1, 0, 0);
      OP_OR:   return mk(EXE_OR,  BR_NONE, 0, 0, 1, 0, 0);
      OP_XOR:  return mk(EXE_XOR, BR_NONE, 0, 0, 1, 0, 0);
      OP_SLL:  return mk(EXE_SLL, BR_NONE, 0, 0, 1, 0, 0);
      OP_SRL:  return mk(EXE_SRL, BR_NONE, 0, 0, 1, 0, 0);
      OP_ADDI: return mk(EXE_ADD, BR_NONE, 0, 0, 1, 1, 1);
      OP_SUBI: return mk(EXE_SUB, BR_NONE, 0, 0, 1, 1, 1);
      OP_LD:   return mk(EXE_ADD, BR_NONE, 1, 0, 1, 1, 1);
      OP_ST:   return mk(EXE_ADD, BR_NONE, 0, 1, 0, 1, 0);
      OP_BEZ:  return mk(EXE_NOP, BR_BEZ,  0, 0, 0, 1, 1);
      OP_BNE:  return mk(EXE_NOP, BR_BNE,  0, 0, 0, 1, 0);
      OP_JMP:  return mk(EXE_NOP, BR_JMP,  0, 0, 0, 1, 1);
      OP_SWP:  return mk(EXE_XOR, BR_NONE, 0, 0, 1, 0, 0);
      default: return mk(EXE_NOP, BR_NONE, 0, 0, 0, 0, 1);
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
    if (wb_we && wb_dest == i) return wb_data;
    return m_regs[i];
  endfunction

  // Write back the model's last expected result, as WB would one cycle later.
  task automatic drive_wb();
    wb_we   = e.valid && e.wb;
    wb_dest = e.dest;
    wb_data = e.v1 ^ e.v2;
  endtask

  // One clock cycle: check combinational outputs, predict the bundle, clock,
  // check registered outputs. Called with inputs already driven.
  task automatic step();
    ref_t rc;
    ex_t  n;
    logic in_swp, swp_ok, bubble, was_rst;
    logic [4:0] a, b;
    #1;
    in_swp = (pend.size() != 0);
    rc     = ref_ctrl(instr[31:26]);
    swp_ok = !in_swp && instr_valid && instr[31:26] == OP_SWP;
    a      = in_swp ? m_a : instr[25:21];
    b      = in_swp ? m_b : instr[20:16];
    obs_freeze = freeze;
    was_rst = rst;
    if (!rst) begin
      check("freeze", freeze, !flush && (hazard || swp_ok || pend.size() == 2));
      check("src1", src1, a);
      check("src2", src2, b);
      check("single_src", single_src, (in_swp || swp_ok) ? 1'b0 : rc.single);
    end

    n = '0;
    bubble = rst || flush || hazard || !(in_swp || instr_valid);
    if (!bubble) begin
      n.valid = 1'b1;
      n.v1 = rd(a);
      n.r2 = rd(b);
      if (in_swp || swp_ok) begin
        n.cmd = EXE_XOR; n.wb = 1'b1;
        n.v2 = rd(b);
        n.dest = in_swp ? pend[0] : a;
      end else begin
        n.cmd = rc.cmd; n.br = rc.br; n.r = rc.r; n.w = rc.w; n.wb = rc.wb;
        n.v2 = rc.imm ? {{16{instr[15]}}, instr[15:0]} : rd(b);
        n.dest = rc.imm ? instr[20:16] : instr[15:11];
      end
    end

    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      pend.delete();
    end else begin
      if (wb_we && wb_dest != 5'd0) m_regs[wb_dest] = wb_data;
      if (flush) pend.delete();
      else if (!hazard) begin
        if (in_swp) void'(pend.pop_front());
        else if (swp_ok) begin
          m_a = instr[25:21]; m_b = instr[20:16];
          pend.push_back(instr[20:16]);
          pend.push_back(instr[25:21]);
        end
      end
    end

    @(posedge clk);
    #1;
    check("ex_valid", ex_valid, n.valid);
    check("exe_cmd", exe_cmd, n.cmd);
    check("br_type", br_type, n.br);
    check("mem_r_en", mem_r_en, n.r);
    check("mem_w_en", mem_w_en, n.w);
    check("wb_en", wb_en, n.wb);
    if (n.valid || was_rst) begin
      check("dest", dest, n.dest);
      check("val1", val1, n.v1);
      check("val2", val2, n.v2);
      check("reg2", reg2, n.r2);
    end
    e = n;
  endtask

  logic [5:0] ops [16];

  initial begin
    ops = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
            OP_ADDI, OP_SUBI, OP_LD, OP_ST, OP_BEZ, OP_BNE, OP_SWP, 6'd63};
    rst = 1'b1; instr = '0; instr_valid = 1'b0; wb_we = 1'b0; wb_dest = '0;
    wb_data = '0; hazard = 1'b0; flush = 1'b0;
    step(); step();
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_exe_cmd", exe_cmd, EXE_NOP);
    check("rst_val2", val2, 32'd0);
    rst = 1'b0;

    // ADDI r3 = r1 + 0xFFFF with r1 = 5
    wb_we = 1'b1; wb_dest = 5'd1; wb_data = 32'd5; step();
    wb_we = 1'b0; instr = {OP_ADDI, 5'd1, 5'd3, 16'hFFFF}; instr_valid = 1'b1; step();
    check("addi_val2", val2, 32'hFFFF_FFFF);
    check("addi_dest", dest, 5'd3);
    check("addi_wb_en", wb_en, 1'b1);
    check("addi_valid", ex_valid, 1'b1);
    check("addi_val1", val1, 32'd5);

    // Write-through bypass, and r0 stays 0
    instr = {OP_ADD, 5'd2, 5'd2, 5'd7, 11'd0};
    wb_we = 1'b1; wb_dest = 5'd2; wb_data = 32'hA5; step();
    check("bypass_val1", val1, 32'hA5);
    check("bypass_reg2", reg2, 32'hA5);
    instr = {OP_ADD, 5'd0, 5'd0, 5'd7, 11'd0}; wb_dest = 5'd0; wb_data = 32'h77; step();
    wb_we = 1'b0; step();
    check("r0_reads_0", val1, 32'd0);

    // SWP r4,r5 with r4=1, r5=2
    instr_valid = 1'b0; wb_we = 1'b1;
    wb_dest = 5'd4; wb_data = 32'd1; step();
    wb_dest = 5'd5; wb_data = 32'd2; step();
    wb_we = 1'b0;
    instr = {OP_SWP, 5'd4, 5'd5, 16'd0}; instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) drive_wb();
      step();
      check("swp_dest", dest, (k == 1) ? 5'd5 : 5'd4);
      check("swp_freeze", obs_freeze, k < 2);
    end
    drive_wb(); instr_valid = 1'b0; step();
    wb_we = 1'b0; instr = {OP_ADD, 5'd4, 5'd5, 5'd0, 11'd0}; instr_valid = 1'b1; step();
    check("swp_r4", val1, 32'd2);
    check("swp_r5", reg2, 32'd1);

    // Hazard for two cycles in SWP1
    instr = {OP_SWP, 5'd4, 5'd5, 16'd0}; step();
    hazard = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_wb(); step();
      check("haz_bubble", ex_valid, 1'b0);
      check("haz_freeze", obs_freeze, 1'b1);
    end
    hazard = 1'b0; drive_wb(); step();
    check("haz_resume_dest", dest, 5'd5);
    drive_wb(); step();
    drive_wb(); instr_valid = 1'b0; step();

    // Flush in SWP1
    instr = {OP_SWP, 5'd1, 5'd3, 16'd0}; instr_valid = 1'b1; wb_we = 1'b0; step();
    drive_wb(); flush = 1'b1; step();
    check("flush_bubble", ex_valid, 1'b0);
    check("flush_freeze", obs_freeze, 1'b0);
    flush = 1'b0; wb_we = 1'b0; instr = {OP_SUB, 5'd1, 5'd2, 5'd9, 11'd0}; step();
    check("flush_idle_cmd", exe_cmd, EXE_SUB);

    // Reset mid-SWP2
    instr = {OP_SWP, 5'd4, 5'd5, 16'd0}; step();
    drive_wb(); step();
    drive_wb(); rst = 1'b1; step();
    check("rstmid_valid", ex_valid, 1'b0);
    check("rstmid_dest", dest, 5'd0);
    check("rstmid_wb_en", wb_en, 1'b0);
    rst = 1'b0; wb_we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      instr = {OP_ADD, 5'(i), 5'(i), 5'd1, 11'd0}; step();
      check("rstmid_reg_zero", val1, 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      instr       = {ops[$urandom_range(0, 15)], 26'($urandom)};
      instr_valid = ($urandom_range(0, 99) < 85);
      hazard      = ($urandom_range(0, 99) < 15);
      flush       = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 1) == 1) drive_wb();
      else begin
        wb_we = $urandom_range(0, 1) == 1; wb_dest = 5'($urandom); wb_data = $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width.
REQ-002 Parameter REG_COUNT, default 32, register-file entries; REG_AW = clog2(REG_COUNT).
REQ-003 Parameter IMM_W, default 16, immediate field width, taken from instr[IMM_W-1:0].
REQ-004 Parameter SWP_EN, default 1, enables the swap micro-op sequencer; 0 decodes SWP as a NOP.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 instr / instr_valid  in  32 / 1  instruction from IF: opcode [31:26], src1 [25:21], src2 [20:16], rd [15:11], imm [IMM_W-1:0].
REQ-008 wb_we, wb_dest, wb_data  in  1, REG_AW, DATA_W  register-file write port from WB.
REQ-009 hazard  in  1  hazard-unit stall request for the current instruction.
REQ-010 flush  in  1  taken-branch kill of the instruction in ID.
REQ-011 src1, src2  out  REG_AW each  combinational source indices for the hazard unit (the current micro-op's sources during SWP).
REQ-012 single_src  out  1  combinational; current micro-op reads src1 only.
REQ-013 freeze  out  1  combinational; IF holds PC and instr this cycle.
REQ-014 Registered ID/EXE outputs: ex_valid 1, dest REG_AW, val1/val2/reg2 DATA_W, exe_cmd 4, br_type 2, mem_r_en, mem_w_en, wb_en 1 each.

Function
REQ-015 Control fields come from the opcode table; is_imm selects val2 = sign-extended imm, otherwise reg[src2].
REQ-016 dest = instr[20:16] when is_imm, else instr[15:11]; reg2 = reg[src2] always.
REQ-017 Register-file reads are combinational with write-through bypass: if wb_we and wb_dest equals a read index other than 0, that read returns wb_data.
REQ-018 Register 0 reads 0; writes to index 0 are ignored.
REQ-019 Registered outputs update every cycle; latency instr -> ex_* is exactly 1 cycle.
REQ-020 Bubble = ex_valid, wb_en, mem_r_en, mem_w_en, br_type all 0 and exe_cmd = NOP; data fields are don't-care but deterministic.
REQ-021 instr_valid=0 or hazard=1 loads a bubble; hazard=1 forces freeze=1 and holds the FSM state.
REQ-022 flush=1 loads a bubble, returns the FSM to IDLE, and forces freeze=0; flush overrides hazard.
REQ-023 FSM states are IDLE, SWP1 and SWP2; a valid SWP in IDLE (SWP_EN=1, no hazard, no flush) emits XOR src1^src2 -> dest=src1 and moves to SWP1.
REQ-024 SWP1 emits XOR -> dest=src2 and moves to SWP2; SWP2 emits XOR -> dest=src1 and moves to IDLE.
REQ-025 freeze=1 in IDLE on a valid SWP and in SWP1; freeze=0 in SWP2, so the next instruction arrives one cycle later.
REQ-026 SWP micro-ops have wb_en=1, is_imm=0, single_src=0, and no memory or branch enables.

Reset
REQ-027 rst=1 clears every register-file entry to 0, sets the FSM to IDLE, and loads a bubble with all ex_* data fields 0.
REQ-028 rst overrides wb_we, hazard and flush; reset mid-SWP abandons the sequence.

Structure
REQ-029 A shared package holds the opcode constants (including SWP), EXE_CMD encodings (NOP, XOR, ...), br_type encodings, the FSM state typedef and the control-word struct.
REQ-030 The register file is one sub-module, id_regfile, parametrised by DATA_W and REG_COUNT, with 2 read ports, 1 write port and bypass.
REQ-031 Opcode decode is a combinational function in the package; target size is 150-300 lines.

Verification
REQ-032 Reset, then ADDI r3 = r1 + imm 0xFFFF with r1=5: next cycle val2=0xFFFFFFFF, dest=3, wb_en=1, ex_valid=1.
REQ-033 wb_we=1, wb_dest=2, wb_data=0xA5 in the same cycle ID reads r2: val1/reg2=0xA5; wb_dest=0 write leaves r0 reading 0.
REQ-034 SWP r4,r5 with r4=1, r5=2 and WB writes applied: dests 4,5,4 on three consecutive cycles, freeze pattern 1,1,0, and final r4=2, r5=1.
REQ-035 hazard=1 for 2 cycles during SWP1: two bubbles, state held, freeze=1, then sequence resumes at dest=5.
REQ-036 flush in SWP1 -> bubble, IDLE, freeze=0; rst mid-SWP2 -> all ex_* 0, r1..r31 read 0.
